rr_arbiter4_nbit: RTL

- Round-robin arbiter and sequencer that shares one n-bit datapath between four requesters.
- Grants one requester at a time and drives the 2-bit select of the downstream 4:1 n-bit mux.
- Moves the granted requester's data into a registered output stage with a valid/ready handshake.
- Sits between the four source channels and the single shared consumer.

---
 rtl/rr_arbiter4_nbit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter4_nbit.sv
// Round-robin arbiter and sequencer for four n-bit requesters sharing one
// datapath. A single requester is granted per burst. Its beats are moved
// into a registered output stage that uses a valid/ready handshake.
module rr_arbiter4_nbit #(
    parameter int n         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [3:0]   last,
    input  logic [n-1:0] i0,
    input  logic [n-1:0] i1,
    input  logic [n-1:0] i2,
    input  logic [n-1:0] i3,
    output logic [3:0]   gnt,
    output logic [1:0]   s,
    output logic [n-1:0] f,
    output logic         f_valid,
    input  logic         f_ready,
    output logic         busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [1:0]    ptr;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_inc;
    logic [n-1:0]  mux_data;
    logic          load_en;
    logic          accept;
    logic          withdraw;
    logic          rel;
    logic          found;
    logic [1:0]    pick;
    logic [1:0]    idx;

    // Downstream 4:1 data mux driven by the current select
    always_comb begin
        case (s)
            2'd0:    mux_data = i0;
            2'd1:    mux_data = i1;
            2'd2:    mux_data = i2;
            default: mux_data = i3;
        endcase
    end

    // Priority scan starting at ptr; first active request wins
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Handshake and release conditions for the granted requester
    always_comb begin
        load_en  = !f_valid | f_ready;
        accept   = |(gnt & req) & load_en;
        cnt_inc  = beat_cnt + 1'b1;
        withdraw = (state == GRANT) && !req[s];
        rel      = (state == GRANT) &&
                   (withdraw || (accept && (last[s] || (cnt_inc == CW'(MAX_BURST)))));
    end

    // Grant FSM, beat counter and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            beat_cnt <= '0;
            gnt      <= '0;
            s        <= '0;
            f        <= '0;
            f_valid  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (accept) begin
                f       <= mux_data;
                f_valid <= 1'b1;
            end else if (f_ready) begin
                f_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        s        <= pick;
                        gnt      <= 4'b0001 << pick;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                default: begin
                    if (accept) begin
                        beat_cnt <= cnt_inc;
                    end
                    if (rel) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= s + 2'd1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
